// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared widths and owner encoding for the data-memory port arbiter.
package dm_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;
endpackage

// File: rtl/dm_arb_if.sv
// dm_arb_if: CPU, DMA and memory-port signals of the data-memory arbiter.
interface dm_arb_if;
    import dm_arb_pkg::*;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_byteen;
    logic [ADDR_W-1:0] cpu_pc;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dma_req_valid;
    logic              dma_req_ready;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [BE_W-1:0]   dma_byteen;
    logic              dma_resp_valid;
    logic              dma_resp_ready;
    logic [DATA_W-1:0] dma_resp_rdata;
    logic [ADDR_W-1:0] m_data_addr;
    logic [DATA_W-1:0] m_data_wdata;
    logic [BE_W-1:0]   m_data_byteen;
    logic [DATA_W-1:0] m_data_rdata;
    logic [ADDR_W-1:0] m_inst_addr;
    logic [1:0]        owner;
    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen, cpu_pc,
        input  dma_req_valid, dma_addr, dma_wdata, dma_byteen, dma_resp_ready,
        input  m_data_rdata,
        output cpu_rdata, cpu_stall, dma_req_ready, dma_resp_valid, dma_resp_rdata,
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, owner
    );
    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_byteen, cpu_pc,
        output dma_req_valid, dma_addr, dma_wdata, dma_byteen, dma_resp_ready,
        output m_data_rdata,
        input  cpu_rdata, cpu_stall, dma_req_ready, dma_resp_valid, dma_resp_rdata,
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, owner
    );
endinterface

// File: rtl/dm_arb_resp_slot.sv
// dm_arb_resp_slot: single outstanding DMA response register; a new push wins over a pop.
module dm_arb_resp_slot
    import dm_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_rdata,
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              pop
);
    assign pop = resp_valid && resp_ready;
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else if (push) begin
            resp_valid <= 1'b1;
            resp_rdata <= push_rdata;
        end else if (pop) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the data-memory port between the CPU M stage and a DMA/debug master.
// Optional address range check enabled by defining DM_ARB_RANGE_CHK_EN (adds sticky addr_err).
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_CPU_RUN = 4,
    parameter int DM_WORDS    = 4096
) (
    input  logic    clk,
    input  logic    reset,
    dm_arb_if.slave bus
`ifdef DM_ARB_RANGE_CHK_EN
    ,
    output logic    addr_err
`endif
);
    localparam logic [3:0] MAX_RUN = 4'(MAX_CPU_RUN);

    if (MAX_CPU_RUN < 1 || MAX_CPU_RUN > 15 || DM_WORDS < 1) begin : g_bad_cfg
        $error("dm_port_arbiter: MAX_CPU_RUN must be 1..15 and DM_WORDS positive");
    end

    logic [3:0]        run_cnt;
    logic [3:0]        run_cnt_n;
    logic              resp_valid;
    logic              resp_pop;
    logic [DATA_W-1:0] resp_rdata;
    logic              dma_eligible;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic              oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] push_rdata;

    // A pending response that pops this cycle frees the slot for a back-to-back request.
    assign dma_eligible = bus.dma_req_valid && (!resp_valid || resp_pop);

    always_comb begin
        cpu_gnt   = reset && bus.cpu_req && (!dma_eligible || run_cnt < MAX_RUN);
        dma_gnt   = reset && dma_eligible && !cpu_gnt;
        run_cnt_n = (cpu_gnt && dma_eligible) ? run_cnt + 4'd1 : 4'd0;
        sel_addr  = cpu_gnt ? bus.cpu_addr : dma_gnt ? bus.dma_addr : '0;
        sel_be    = cpu_gnt ? bus.cpu_byteen : dma_gnt ? bus.dma_byteen : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            run_cnt <= 4'd0;
        else
            run_cnt <= run_cnt_n;
    end

`ifdef DM_ARB_RANGE_CHK_EN
    assign oor = (cpu_gnt || dma_gnt) && ({2'b00, sel_addr[ADDR_W-1:2]} >= 32'(DM_WORDS));
    always_ff @(posedge clk) begin
        if (!reset)
            addr_err <= 1'b0;
        else if (oor)
            addr_err <= 1'b1;
    end
`else
    assign oor = 1'b0;
`endif

    always_comb begin
        bus.m_data_addr    = sel_addr;
        bus.m_data_wdata   = cpu_gnt ? bus.cpu_wdata : dma_gnt ? bus.dma_wdata : '0;
        bus.m_data_byteen  = oor ? '0 : sel_be;
        bus.cpu_rdata      = (cpu_gnt && !oor) ? bus.m_data_rdata : '0;
        bus.cpu_stall      = reset && bus.cpu_req && !cpu_gnt;
        bus.m_inst_addr    = cpu_gnt ? bus.cpu_pc : '0;
        bus.owner          = cpu_gnt ? OWN_CPU : dma_gnt ? OWN_DMA : OWN_NONE;
        bus.dma_req_ready  = dma_gnt;
        bus.dma_resp_valid = resp_valid;
        bus.dma_resp_rdata = resp_rdata;
        push_rdata         = (bus.dma_byteen == '0 && !oor) ? bus.m_data_rdata : '0;
    end

    dm_arb_resp_slot u_resp_slot (
        .clk        (clk),
        .reset      (reset),
        .push       (dma_gnt),
        .push_rdata (push_rdata),
        .resp_ready (bus.dma_resp_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .pop        (resp_pop)
    );
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed scenarios plus randomized traffic checked against a reference model.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int passes = 0;
    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    int m_run;
    bit m_rv;
    logic [31:0] m_rd;

    dm_arb_if bus();
`ifdef DM_ARB_RANGE_CHK_EN
    logic addr_err;
`endif

    dm_port_arbiter #(.MAX_CPU_RUN(MAX), .DM_WORDS(4096)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DM_ARB_RANGE_CHK_EN
        ,
        .addr_err (addr_err)
`endif
    );

    always #5 clk = ~clk;

    // Memory environment: combinational read, byte-lane write on posedge.
    assign bus.m_data_rdata = mem[bus.m_data_addr[13:2]];
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (bus.m_data_byteen[i]) mem[bus.m_data_addr[13:2]][8*i +: 8] <= bus.m_data_wdata[8*i +: 8];

    // Reference: who should own the port this cycle (0 none, 1 CPU, 2 DMA).
    function automatic int exp_owner();
        bit elig;
        elig = bus.dma_req_valid && (!m_rv || bus.dma_resp_ready);
        if (!reset) return 0;
        if (bus.cpu_req && !(elig && m_run >= MAX)) return 1;
        return elig ? 2 : 0;
    endfunction

    always @(posedge clk) begin
        int g;
        bit elig;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0] be;
        g = exp_owner();
        elig = bus.dma_req_valid && (!m_rv || bus.dma_resp_ready);
        a = g == 1 ? bus.cpu_addr : bus.dma_addr;
        be = g == 1 ? bus.cpu_byteen : bus.dma_byteen;
        wd = g == 1 ? bus.cpu_wdata : bus.dma_wdata;
        if (!reset) begin
            m_run = 0;
            m_rv = 0;
            m_rd = 0;
        end else begin
            if (g == 2) begin
                m_rv = 1;
                m_rd = (be == 0 && a[31:2] < 4096) ? ref_mem[a[13:2]] : 32'h0;
            end else if (m_rv && bus.dma_resp_ready) begin
                m_rv = 0;
            end
            m_run = (g == 1 && elig) ? m_run + 1 : 0;
            if (g != 0 && a[31:2] < 4096)
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[a[13:2]][8*i +: 8] = wd[8*i +: 8];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_byteen = 0; bus.cpu_pc = 0;
        bus.dma_req_valid = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_byteen = 0;
        bus.dma_resp_ready = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        bus.cpu_req = 1; bus.cpu_byteen = 4'hF; bus.cpu_addr = 32'h10;
        bus.dma_req_valid = 1;
        @(negedge clk);
        checks++; if (bus.owner !== 2'd0) $display("FAIL reset owner got %0d want 0", bus.owner); else passes++;
        checks++; if (bus.m_data_byteen !== 4'h0) $display("FAIL reset byteen got %h want 0", bus.m_data_byteen); else passes++;
        checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL reset cpu_stall got %b want 0", bus.cpu_stall); else passes++;
        checks++; if (bus.dma_req_ready !== 1'b0) $display("FAIL reset dma_req_ready got %b want 0", bus.dma_req_ready); else passes++;
        checks++; if (bus.dma_resp_valid !== 1'b0) $display("FAIL reset resp_valid got %b want 0", bus.dma_resp_valid); else passes++;
        next_cycle();
        idle_inputs();
        reset = 1;
    endtask

    task automatic test_cpu_alone();
        bus.cpu_req = 1; bus.cpu_addr = 32'h10; bus.cpu_byteen = 4'hF; bus.cpu_wdata = 32'hDEADBEEF; bus.cpu_pc = 32'h100;
        @(negedge clk);
        checks++; if (bus.m_data_byteen !== 4'hF) $display("FAIL cpu store byteen got %h want f", bus.m_data_byteen); else passes++;
        checks++; if (bus.m_data_addr !== 32'h10) $display("FAIL cpu store addr got %h want 10", bus.m_data_addr); else passes++;
        checks++; if (bus.cpu_stall !== 1'b0) $display("FAIL cpu store stall got %b want 0", bus.cpu_stall); else passes++;
        checks++; if (bus.m_inst_addr !== 32'h100) $display("FAIL cpu store m_inst_addr got %h want 100", bus.m_inst_addr); else passes++;
        checks++; if (bus.owner !== 2'd1) $display("FAIL cpu store owner got %0d want 1", bus.owner); else passes++;
        next_cycle();
        bus.cpu_byteen = 0; bus.cpu_pc = 32'h104;
        @(negedge clk);
        checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) $display("FAIL cpu load rdata got %h want deadbeef", bus.cpu_rdata); else passes++;
        next_cycle();
        bus.cpu_req = 0;
        @(negedge clk);
        checks++; if (bus.owner !== 2'd0) $display("FAIL idle owner got %0d want 0", bus.owner); else passes++;
        checks++; if (bus.cpu_rdata !== 32'h0) $display("FAIL idle cpu_rdata got %h want 0", bus.cpu_rdata); else passes++;
        checks++; if (bus.m_inst_addr !== 32'h0) $display("FAIL idle m_inst_addr got %h want 0", bus.m_inst_addr); else passes++;
        next_cycle();
    endtask

    task automatic test_dma_alone();
        bus.dma_req_valid = 1; bus.dma_addr = 32'h20; bus.dma_wdata = 32'h12345678; bus.dma_byteen = 4'hF; bus.dma_resp_ready = 1;
        @(negedge clk);
        checks++; if (bus.dma_req_ready !== 1'b1) $display("FAIL dma write ready got %b want 1", bus.dma_req_ready); else passes++;
        checks++; if (bus.m_data_byteen !== 4'hF) $display("FAIL dma write byteen got %h want f", bus.m_data_byteen); else passes++;
        next_cycle();
        bus.dma_byteen = 0;
        @(negedge clk);
        checks++; if (bus.dma_req_ready !== 1'b1) $display("FAIL dma read ready got %b want 1", bus.dma_req_ready); else passes++;
        checks++; if (bus.dma_resp_valid !== 1'b1) $display("FAIL dma write resp_valid got %b want 1", bus.dma_resp_valid); else passes++;
        checks++; if (bus.dma_resp_rdata !== 32'h0) $display("FAIL dma write resp_rdata got %h want 0", bus.dma_resp_rdata); else passes++;
        next_cycle();
        bus.dma_req_valid = 0;
        @(negedge clk);
        checks++; if (bus.dma_resp_valid !== 1'b1) $display("FAIL dma read resp_valid got %b want 1", bus.dma_resp_valid); else passes++;
        checks++; if (bus.dma_resp_rdata !== 32'h12345678) $display("FAIL dma read resp_rdata got %h want 12345678", bus.dma_resp_rdata); else passes++;
        next_cycle();
        @(negedge clk);
        checks++; if (bus.dma_resp_valid !== 1'b0) $display("FAIL dma resp drained got %b want 0", bus.dma_resp_valid); else passes++;
        next_cycle();
    endtask

    task automatic test_contention();
        bus.cpu_req = 1; bus.cpu_addr = 32'h10; bus.cpu_byteen = 0;
        bus.dma_req_valid = 1; bus.dma_addr = 32'h20; bus.dma_byteen = 0; bus.dma_resp_ready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (bus.owner !== ((i % 5 == 4) ? 2'd2 : 2'd1)) $display("FAIL contention owner cycle %0d got %0d", i, bus.owner); else passes++;
            checks++; if (bus.cpu_stall !== (i % 5 == 4)) $display("FAIL contention stall cycle %0d got %b", i, bus.cpu_stall); else passes++;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bus.dma_req_valid = 1; bus.dma_addr = 32'h20; bus.dma_byteen = 0; bus.dma_resp_ready = 0;
        @(negedge clk);
        checks++; if (bus.dma_req_ready !== 1'b1) $display("FAIL bp first ready got %b want 1", bus.dma_req_ready); else passes++;
        next_cycle();
        bus.cpu_req = 1; bus.cpu_addr = 32'h10; bus.cpu_byteen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.dma_req_ready !== 1'b0) $display("FAIL bp held ready got %b want 0", bus.dma_req_ready); else passes++;
            checks++; if (bus.owner !== 2'd1) $display("FAIL bp cpu owner got %0d want 1", bus.owner); else passes++;
            checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) $display("FAIL bp cpu_rdata got %h want deadbeef", bus.cpu_rdata); else passes++;
            checks++; if (bus.dma_resp_rdata !== 32'h12345678) $display("FAIL bp resp_rdata got %h want 12345678", bus.dma_resp_rdata); else passes++;
            next_cycle();
        end
        bus.cpu_req = 0; bus.dma_resp_ready = 1; bus.dma_addr = 32'h10;
        @(negedge clk);
        checks++; if (bus.dma_req_ready !== 1'b1) $display("FAIL bp pop regrant ready got %b want 1", bus.dma_req_ready); else passes++;
        next_cycle();
        bus.dma_req_valid = 0; bus.dma_resp_ready = 0;
        @(negedge clk);
        checks++; if (bus.dma_resp_valid !== 1'b1) $display("FAIL bp resp_valid kept got %b want 1", bus.dma_resp_valid); else passes++;
        checks++; if (bus.dma_resp_rdata !== 32'hDEADBEEF) $display("FAIL bp new resp_rdata got %h want deadbeef", bus.dma_resp_rdata); else passes++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        reset = 0;
        next_cycle();
        reset = 1;
        @(negedge clk);
        checks++; if (bus.dma_resp_valid !== 1'b0) $display("FAIL mid reset resp dropped got %b want 0", bus.dma_resp_valid); else passes++;
        next_cycle();
        bus.cpu_req = 1; bus.dma_req_valid = 1; bus.dma_byteen = 0; bus.dma_resp_ready = 1;
        repeat (3) next_cycle();
        reset = 0;
        @(negedge clk);
        checks++; if (bus.m_data_byteen !== 4'h0 || bus.owner !== 2'd0) $display("FAIL mid reset idle got be=%h owner=%0d want 0/0", bus.m_data_byteen, bus.owner); else passes++;
        checks++; if (bus.dma_req_ready !== 1'b0 || bus.cpu_stall !== 1'b0) $display("FAIL mid reset handshake got rdy=%b stall=%b want 0/0", bus.dma_req_ready, bus.cpu_stall); else passes++;
        next_cycle();
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.owner !== ((i == 4) ? 2'd2 : 2'd1)) $display("FAIL post reset run cycle %0d owner got %0d", i, bus.owner); else passes++;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

`ifdef DM_ARB_RANGE_CHK_EN
    task automatic test_range();
        bus.cpu_req = 1; bus.cpu_addr = 32'h4000; bus.cpu_byteen = 4'hF; bus.cpu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (bus.m_data_byteen !== 4'h0) $display("FAIL range byteen got %h want 0", bus.m_data_byteen); else passes++;
        checks++; if (addr_err !== 1'b0) $display("FAIL range addr_err early got %b want 0", addr_err); else passes++;
        next_cycle();
        idle_inputs();
        bus.dma_req_valid = 1; bus.dma_addr = 32'h4000;
        @(negedge clk);
        checks++; if (addr_err !== 1'b1) $display("FAIL range addr_err got %b want 1", addr_err); else passes++;
        checks++; if (bus.dma_req_ready !== 1'b1) $display("FAIL range dma ready got %b want 1", bus.dma_req_ready); else passes++;
        next_cycle();
        bus.dma_req_valid = 0;
        @(negedge clk);
        checks++; if (bus.dma_resp_valid !== 1'b1 || bus.dma_resp_rdata !== 32'h0) $display("FAIL range dma resp got v=%b d=%h want 1/0", bus.dma_resp_valid, bus.dma_resp_rdata); else passes++;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++; if (addr_err !== 1'b1) $display("FAIL range addr_err sticky got %b want 1", addr_err); else passes++;
        next_cycle();
        reset = 0;
        next_cycle();
        reset = 1;
        @(negedge clk);
        checks++; if (addr_err !== 1'b0) $display("FAIL range addr_err cleared got %b want 0", addr_err); else passes++;
        next_cycle();
    endtask
`endif

    task automatic test_random(int n);
        int g;
        logic [31:0] ea;
        for (int k = 0; k < n; k++) begin
            reset = ($urandom_range(0, 39) != 0);
            bus.cpu_req = 1'($urandom_range(0, 1));
            bus.cpu_addr = 32'($urandom_range(0, 255));
            bus.cpu_byteen = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus.cpu_wdata = $urandom;
            bus.cpu_pc = $urandom;
            bus.dma_req_valid = 1'($urandom_range(0, 1));
            bus.dma_addr = 32'($urandom_range(0, 255));
            bus.dma_byteen = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus.dma_wdata = $urandom;
            bus.dma_resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = exp_owner();
            ea = g == 1 ? bus.cpu_addr : g == 2 ? bus.dma_addr : 32'h0;
            checks++; if (bus.owner !== 2'(g)) $display("FAIL rnd owner got %0d want %0d", bus.owner, g); else passes++;
            checks++; if (bus.m_data_addr !== ea) $display("FAIL rnd addr got %h want %h", bus.m_data_addr, ea); else passes++;
            checks++; if (bus.m_data_byteen !== (g == 1 ? bus.cpu_byteen : g == 2 ? bus.dma_byteen : 4'h0)) $display("FAIL rnd byteen got %h owner %0d", bus.m_data_byteen, g); else passes++;
            checks++; if (bus.m_data_wdata !== (g == 1 ? bus.cpu_wdata : g == 2 ? bus.dma_wdata : 32'h0)) $display("FAIL rnd wdata got %h owner %0d", bus.m_data_wdata, g); else passes++;
            checks++; if (bus.cpu_stall !== (reset && bus.cpu_req && g != 1)) $display("FAIL rnd cpu_stall got %b owner %0d", bus.cpu_stall, g); else passes++;
            checks++; if (bus.dma_req_ready !== (g == 2)) $display("FAIL rnd dma_req_ready got %b owner %0d", bus.dma_req_ready, g); else passes++;
            checks++; if (bus.m_inst_addr !== (g == 1 ? bus.cpu_pc : 32'h0)) $display("FAIL rnd m_inst_addr got %h owner %0d", bus.m_inst_addr, g); else passes++;
            checks++; if (bus.cpu_rdata !== (g == 1 ? ref_mem[bus.cpu_addr[13:2]] : 32'h0)) $display("FAIL rnd cpu_rdata got %h want %h", bus.cpu_rdata, g == 1 ? ref_mem[bus.cpu_addr[13:2]] : 32'h0); else passes++;
            checks++; if (bus.dma_resp_valid !== m_rv) $display("FAIL rnd resp_valid got %b want %b", bus.dma_resp_valid, m_rv); else passes++;
            if (m_rv) begin
                checks++; if (bus.dma_resp_rdata !== m_rd) $display("FAIL rnd resp_rdata got %h want %h", bus.dma_resp_rdata, m_rd); else passes++;
            end
            next_cycle();
        end
        reset = 1;
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        m_run = 0;
        m_rv = 0;
        m_rd = 0;
        idle_inputs();
        reset = 0;
        next_cycle();
        test_reset();
        test_cpu_alone();
        test_dma_alone();
        test_contention();
        test_back_to_back();
        test_reset_mid();
`ifdef DM_ARB_RANGE_CHK_EN
        test_range();
`endif
        test_random(400);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
